scan_ctrl: RTL
==============

# scan_ctrl

Single-clock sequencer that drives a chain of two-phase scan cells from the system clock. It generates non-overlapping CLK1/CLK2 scan clock pulses, the CAPTURE and UPDATE strobes, and the serial SCAN_IN stream. It also collects the chain's serial SCAN_OUT into a parallel readback word. It sits directly upstream of the scan chain and is the only agent that toggles the chain's control pins.

## Interface
Parameters:
- CHAIN_LEN, 16: number of scan cells in the chain (2..256).
- CNT_W, $clog2(CHAIN_LEN): bit counter width.

Ports:
- CLK  in  1  system clock; the only clock; every output is registered on its rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  request a scan operation; sampled only in IDLE.
- DO_CAPTURE  in  1  sampled with START; performs a capture before shifting.
- DO_UPDATE  in  1  sampled with START; performs an update after shifting.
- WDATA  in  CHAIN_LEN  word to shift in; bit 0 is shifted first.
- RDATA  out  CHAIN_LEN  word shifted out; bit 0 is the first bit sampled.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle completion pulse.
- SCAN_CLK1  out  1  to chain CLK1.
- SCAN_CLK2  out  1  to chain CLK2.
- SCAN_IN_O  out  1  to the first cell's SCAN_IN.
- SCAN_OUT_I  in  1  from the last cell's SCAN_OUT.
- SCAN_CAPTURE  out  1  to chain CAPTURE.
- SCAN_UPDATE  out  1  to chain UPDATE.

## Operation
- States: IDLE, CAPT, SHIFT, UPDT, FIN.
- IDLE → START=1: latch WDATA into the shift register and latch DO_CAPTURE/DO_UPDATE. Next state is CAPT if DO_CAPTURE, otherwise SHIFT.
- CAPT: 4 phases P0..P3.
  - SCAN_CAPTURE=1 in P0–P2 and 0 in P3.
  - SCAN_CLK2=1 in P1 only.
  - Then → SHIFT.
- SHIFT: CHAIN_LEN bits, 4 phases per bit.
  - P0: SCAN_IN_O = current shift bit; SCAN_CLK1=1.
  - P1: both clocks low; sample SCAN_OUT_I into RDATA[bit].
  - P2: SCAN_CLK2=1.
  - P3: both clocks low; advance the bit counter.
  - SCAN_IN_O holds its value from P0 through P3.
- After the last bit: → UPDT if DO_UPDATE, otherwise → FIN.
- UPDT: U0 with SCAN_UPDATE=0 (setup), U1 with SCAN_UPDATE=1, then → FIN.
- FIN: DONE=1 for one cycle, then → IDLE.
- SCAN_CLK1 and SCAN_CLK2 are never high in the same cycle. Every clock high is preceded and followed by at least one cycle with both clocks low.
- START while BUSY is ignored. WDATA changes after START are ignored.
- RDATA updates bit-by-bit during SHIFT and holds its final value until the next SHIFT.

## Timing
- Reset values: all outputs 0, RDATA=0, state IDLE. Reset takes effect at the next CLK edge and is honoured mid-operation: clocks and strobes drop low in the same cycle and no DONE is issued.
- START sampled at edge 0 → BUSY=1 from edge 1.
- DONE is asserted at edge 1 + 4·C + 4·CHAIN_LEN + 2·U, where C = DO_CAPTURE and U = DO_UPDATE.
- BUSY falls with the DONE cycle's successor, i.e. BUSY is high during the DONE cycle.
- Back-to-back operation: START asserted during DONE is ignored. START in the first IDLE cycle after DONE is accepted.

## Configuration
- SCAN_CTRL_STRETCH_EN defined: every phase (CAPT P0–P3, SHIFT P0–P3, UPDT U0/U1) lasts 2 CLK cycles. This gives slow chains a half-speed scan clock. The DONE formula doubles every term except the leading 1. Sampling moves to the second cycle of P1.
- SCAN_CTRL_STRETCH_EN undefined: one cycle per phase, as specified above.

## Test plan
- Shift only, CHAIN_LEN=16, WDATA=16'hA5C3, chain preloaded 16'h1234 → RDATA=16'h1234 and chain contents 16'hA5C3. DONE at edge 65. SCAN_UPDATE never toggles.
- Capture+shift+update, chain capture inputs 16'hBEEF, WDATA=16'h0F0F → RDATA=16'hBEEF. Chain update outputs = 16'h0F0F after edge 70. DONE at edge 71.
- Non-overlap monitor across a full capture+shift+update run → zero cycles with SCAN_CLK1 & SCAN_CLK2, and zero CLK1/CLK2 edges in adjacent cycles.
- RESET=0 at SHIFT bit 5 P0 → next edge: all outputs 0, state IDLE. A new START with WDATA=16'hFFFF then completes normally with DONE at edge 65.
- START pulsed at edges 10 and 30 while BUSY → exactly one DONE, and RDATA reflects only the first operation.
- With SCAN_CTRL_STRETCH_EN defined, shift only, CHAIN_LEN=16 → DONE at edge 129, and every clock pulse is 2 cycles wide.

Source files
------------

// File: rtl/scan_ctrl_if.sv
// Host/chain-side bundle for scan_ctrl: request handshake, readback and chain control pins.
interface scan_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 START;
  logic                 DO_CAPTURE;
  logic                 DO_UPDATE;
  logic [CHAIN_LEN-1:0] WDATA;
  logic [CHAIN_LEN-1:0] RDATA;
  logic                 BUSY;
  logic                 DONE;
  logic                 SCAN_CLK1;
  logic                 SCAN_CLK2;
  logic                 SCAN_IN_O;
  logic                 SCAN_OUT_I;
  logic                 SCAN_CAPTURE;
  logic                 SCAN_UPDATE;

  modport master (
    output START, DO_CAPTURE, DO_UPDATE, WDATA, SCAN_OUT_I,
    input  RDATA, BUSY, DONE, SCAN_CLK1, SCAN_CLK2, SCAN_IN_O, SCAN_CAPTURE, SCAN_UPDATE
  );

  modport slave (
    input  START, DO_CAPTURE, DO_UPDATE, WDATA, SCAN_OUT_I,
    output RDATA, BUSY, DONE, SCAN_CLK1, SCAN_CLK2, SCAN_IN_O, SCAN_CAPTURE, SCAN_UPDATE
  );
endinterface

// File: rtl/scan_ctrl.sv
// Two-phase scan chain sequencer: optional capture, serial shift with readback, optional update.
// Build option SCAN_CTRL_STRETCH_EN: every phase lasts two CLK cycles (half-speed scan clock).
module scan_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input logic        CLK,
  input logic        RESET,
  scan_ctrl_if.slave bus
);

`ifdef SCAN_CTRL_STRETCH_EN
  localparam logic SUB_LAST = 1'b1;
`else
  localparam logic SUB_LAST = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_UPDT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [1:0]           phase_r, phase_nxt_s;
  logic                 sub_r, sub_nxt_s;
  logic [CNT_W-1:0]     bit_r, bit_nxt_s;
  logic [CHAIN_LEN-1:0] sreg_r, rdata_r;
  logic                 do_upd_r;
  logic                 busy_r, done_r, clk1_r, clk2_r, sin_r, capt_r, upd_r;
  logic                 busy_s, done_s, clk1_s, clk2_s, sin_s, capt_s, upd_s;
  logic                 start_ok_s, phase_end_s, last_bit_s, sample_s, advance_s;

  // done_r blocks a START that arrives while DONE is still showing
  assign start_ok_s  = (state_r == ST_IDLE) && bus.START && !done_r;
  assign phase_end_s = (sub_r == SUB_LAST);
  assign last_bit_s  = (bit_r == CNT_W'(CHAIN_LEN - 1));
  assign sample_s    = (state_r == ST_SHIFT) && (phase_r == 2'd2) && (sub_r == 1'b0);
  assign advance_s   = (state_r == ST_SHIFT) && (phase_r == 2'd3) && phase_end_s;

  // State register plus output registers (outputs trail the state by one cycle)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      phase_r <= 2'd0;
      sub_r   <= 1'b0;
      bit_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      clk1_r  <= 1'b0;
      clk2_r  <= 1'b0;
      sin_r   <= 1'b0;
      capt_r  <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
      sub_r   <= sub_nxt_s;
      bit_r   <= bit_nxt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      clk1_r  <= clk1_s;
      clk2_r  <= clk2_s;
      sin_r   <= sin_s;
      capt_r  <= capt_s;
      upd_r   <= upd_s;
    end
  end

  // Next-state sequencing through phases, bits and states
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    sub_nxt_s   = sub_r;
    bit_nxt_s   = bit_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = bus.DO_CAPTURE ? ST_CAPT : ST_SHIFT;
          phase_nxt_s = 2'd0;
          sub_nxt_s   = 1'b0;
          bit_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPT, ST_SHIFT, ST_UPDT: begin
        if (!phase_end_s) begin
          sub_nxt_s = sub_r + 1'b1;
        end else begin
          sub_nxt_s   = 1'b0;
          phase_nxt_s = phase_r + 2'd1;
          if ((state_r == ST_CAPT) && (phase_r == 2'd3)) begin
            state_nxt_s = ST_SHIFT;
          end else if ((state_r == ST_SHIFT) && (phase_r == 2'd3)) begin
            if (last_bit_s) begin
              state_nxt_s = do_upd_r ? ST_UPDT : ST_FIN;
            end else begin
              bit_nxt_s = bit_r + CNT_W'(1);
            end
          end else if ((state_r == ST_UPDT) && (phase_r == 2'd1)) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Phase decode of scan clocks and strobes
  always_comb begin
    busy_s = (state_r != ST_IDLE);
    done_s = (state_r == ST_FIN);
    clk1_s = 1'b0;
    clk2_s = 1'b0;
    sin_s  = 1'b0;
    capt_s = 1'b0;
    upd_s  = 1'b0;
    case (state_r)
      ST_CAPT: begin
        capt_s = (phase_r != 2'd3);
        clk2_s = (phase_r == 2'd1);
      end
      ST_SHIFT: begin
        clk1_s = (phase_r == 2'd0);
        clk2_s = (phase_r == 2'd2);
        sin_s  = sreg_r[0];
      end
      ST_UPDT: upd_s = (phase_r == 2'd1);
      default: begin
        clk1_s = 1'b0;
      end
    endcase
  end

  // Shift-in word, update flag and readback; SCAN_OUT_I is taken while the chain sees P1
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sreg_r   <= '0;
      rdata_r  <= '0;
      do_upd_r <= 1'b0;
    end else begin
      if (start_ok_s) begin
        sreg_r   <= bus.WDATA;
        do_upd_r <= bus.DO_UPDATE;
      end else if (advance_s) begin
        sreg_r <= {1'b0, sreg_r[CHAIN_LEN-1:1]};
      end
      if (sample_s) begin
        rdata_r[bit_r] <= bus.SCAN_OUT_I;
      end
    end
  end

  assign bus.RDATA        = rdata_r;
  assign bus.BUSY         = busy_r;
  assign bus.DONE         = done_r;
  assign bus.SCAN_CLK1    = clk1_r;
  assign bus.SCAN_CLK2    = clk2_r;
  assign bus.SCAN_IN_O    = sin_r;
  assign bus.SCAN_CAPTURE = capt_r;
  assign bus.SCAN_UPDATE  = upd_r;

endmodule
